// File: rtl/his_readout_fsm.sv
// Histogram readout: sweeps a completed bank bin by bin, streams counts downstream and reports the peak bin.
// Build option HIS_READ_CLEAR_EN: zero each bin in the RAM as it is accepted downstream.
module his_readout_fsm #(
    parameter int BIN_NUM = 64,
    parameter int ADDR_W  = 6,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              acq_done,
    input  logic              bank_sel,
    output logic              ram_rd_en,
    output logic              ram_rd_bank,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [CNT_W-1:0]  ram_rd_data,
    output logic              ram_clr_en,
    output logic [ADDR_W-1:0] ram_clr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_bin,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_last,
    output logic              peak_valid,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [CNT_W-1:0]  peak_count,
    output logic              busy,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BIN_NUM - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic              bank;
    logic              accept;

    // Output handshake: a beat transfers on every clock edge where out_valid && out_ready.
    // Once raised, out_valid stays high and out_bin/out_count/out_last stay unchanged until
    // that edge; out_ready is ignored while out_valid is low.
    assign accept = (state == SEND) && out_ready;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acq_done) state_nxt = READ;
            READ: state_nxt = CAPT;
            CAPT: state_nxt = SEND;
            SEND: if (accept) state_nxt = out_last ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            addr       <= '0;
            bank       <= 1'b0;
            out_valid  <= 1'b0;
            out_bin    <= '0;
            out_count  <= '0;
            out_last   <= 1'b0;
            peak_bin   <= '0;
            peak_count <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (acq_done && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (acq_done) begin
                        bank       <= bank_sel;
                        addr       <= '0;
                        peak_bin   <= '0;
                        peak_count <= '0;
                        busy       <= 1'b1;
                    end
                end
                CAPT: begin
                    out_count <= ram_rd_data;
                    out_bin   <= addr;
                    out_valid <= 1'b1;
                    out_last  <= (addr == LAST_ADDR);
                    // Strict compare keeps the lowest index on ties.
                    if (ram_rd_data > peak_count) begin
                        peak_count <= ram_rd_data;
                        peak_bin   <= addr;
                    end
                end
                SEND: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!out_last) begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ram_rd_en   = (state == READ);
    assign ram_rd_bank = bank;
    assign ram_rd_addr = addr;
    assign peak_valid  = (state == DONE);
    assign dbg_state   = state;

`ifdef HIS_READ_CLEAR_EN
    assign ram_clr_en   = accept;
    assign ram_clr_addr = out_bin;
`else
    assign ram_clr_en   = 1'b0;
    assign ram_clr_addr = '0;
`endif

endmodule
